// File: rtl/neuron_pkg.sv
// neuron_pkg: FSM state type, width helpers and default sizing shared by the
// neuron layer sequencer and its evaluator.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NEURONS     = 4;
  localparam int DEF_CONNECTIONS = 2;
  localparam int DEF_THRESHOLD   = DEF_CONNECTIONS / 2;
  localparam int DEF_LAYERS      = 2;

  // Index counters cover 0..n-1 but never collapse to zero width.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int pop_width(input int c);
    return $clog2(c + 1);
  endfunction

  localparam int IDX_W = cnt_width(DEF_NEURONS);
  localparam int LAY_W = cnt_width(DEF_LAYERS);
  localparam int POP_W = pop_width(DEF_CONNECTIONS);

endpackage

// File: rtl/neuron_layer_sequencer_eval.sv
// neuron_eval: combinational threshold neuron; fires when fewer than THRESHOLD
// of its CONNECTIONS inputs are set, and stays at 0 when disabled.
module neuron_eval
  import neuron_pkg::*;
#(
  parameter int CONNECTIONS = DEF_CONNECTIONS,
  parameter int THRESHOLD   = CONNECTIONS / 2
) (
  input  logic                   enable,
  input  logic [CONNECTIONS-1:0] in,
  output logic                   out
);

  localparam int PW = pop_width(CONNECTIONS);

  logic [PW-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int j = 0; j < CONNECTIONS; j++) cnt = cnt + PW'(in[j]);
  end

  assign out = enable && (cnt < PW'(THRESHOLD));

endmodule

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: time-multiplexes one neuron_eval over a ring-wired
// layer, one neuron per clock, for LAYERS passes. NEURON_SEQ_MASK_EN adds a mask.
module neuron_layer_sequencer
  import neuron_pkg::*;
#(
  parameter int NEURONS     = DEF_NEURONS,
  parameter int CONNECTIONS = DEF_CONNECTIONS,
  parameter int THRESHOLD   = CONNECTIONS / 2,
  parameter int LAYERS      = DEF_LAYERS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NEURONS-1:0] in_vec,
`ifdef NEURON_SEQ_MASK_EN
  input  logic [NEURONS-1:0] neuron_mask,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NEURONS-1:0] out_vec,
  output logic               busy
);

  localparam int IW = cnt_width(NEURONS);
  localparam int LW = cnt_width(LAYERS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NEURONS - 1);
  localparam logic [LW-1:0] LAY_LAST = LW'(LAYERS - 1);

  state_t                 state, state_nxt;
  logic [NEURONS-1:0]     cur_vec, nxt_vec, layer_vec;
  logic [IW-1:0]          idx;
  logic [LW-1:0]          lay;
  logic [CONNECTIONS-1:0] taps;
  logic                   enable, fire, accept, layer_end;

`ifdef NEURON_SEQ_MASK_EN
  logic [NEURONS-1:0] mask_q;
  assign enable = mask_q[idx];
`else
  assign enable = 1'b1;
`endif

  assign accept    = in_valid && in_ready;
  assign layer_end = (idx == IDX_LAST);

  // Ring tap selection: neuron idx reads cur_vec[(idx+j) mod NEURONS].
  always_comb begin
    logic [IW:0] pos;
    taps = '0;
    pos  = '0;
    for (int j = 0; j < CONNECTIONS; j++) begin
      pos = {1'b0, idx} + (IW+1)'(j);
      if (pos >= (IW+1)'(NEURONS)) pos = pos - (IW+1)'(NEURONS);
      taps[j] = cur_vec[pos[IW-1:0]];
    end
  end

  neuron_eval #(
    .CONNECTIONS (CONNECTIONS),
    .THRESHOLD   (THRESHOLD)
  ) u_eval (
    .enable (enable),
    .in     (taps),
    .out    (fire)
  );

  // The last neuron's result is not in nxt_vec yet, so merge it in directly.
  always_comb begin
    layer_vec      = nxt_vec;
    layer_vec[idx] = fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EVAL;
      EVAL:    if (layer_end && (lay == LAY_LAST)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == EVAL);
    out_valid = (state == DONE);
    out_vec   = (state == DONE) ? cur_vec : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_vec <= '0;
      nxt_vec <= '0;
      idx     <= '0;
      lay     <= '0;
`ifdef NEURON_SEQ_MASK_EN
      mask_q  <= '0;
`endif
    end else if (accept) begin
      cur_vec <= in_vec;
      idx     <= '0;
      lay     <= '0;
`ifdef NEURON_SEQ_MASK_EN
      mask_q  <= neuron_mask;
`endif
    end else if (state == EVAL) begin
      nxt_vec[idx] <= fire;
      if (layer_end) begin
        cur_vec <= layer_vec;
        idx     <= '0;
        if (lay != LAY_LAST) lay <= lay + 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
- Time-multiplexed controller that runs one shared threshold-neuron evaluator over a ring-wired layer of NEURONS neurons, one neuron per clock.
- Repeats this for LAYERS passes. Each layer's output vector becomes the next layer's input.
- Accepts an input vector with a valid/ready handshake and returns the final layer vector with a valid/ready handshake.
- Sits between the stimulus/interface logic and the network output, replacing NEURONS parallel neuron instances with one evaluator.

Parameters:
- NEURONS, 4, neurons per layer; also the width of the input and output vectors (min 2).
- CONNECTIONS, 2, inputs per neuron (1..NEURONS).
- THRESHOLD, CONNECTIONS/2, static firing threshold.
- LAYERS, 2, number of layer passes (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector offered.
- in_ready  out  1  sequencer can accept a vector.
- in_vec  in  NEURONS  input activation vector.
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts result.
- out_vec  out  NEURONS  final layer activations.
- busy  out  1  evaluation in progress.

Behaviour:
- Wiring: neuron k reads cur[(k+j) mod NEURONS] for j = 0..CONNECTIONS-1.
- Neuron rule: out = 1 when popcount of its inputs < THRESHOLD, else 0. Disabled neuron outputs 0. Popcount width is clog2(CONNECTIONS+1); comparison is unsigned.
- Registers: cur_vec and nxt_vec (NEURONS each), neuron index idx (clog2 NEURONS), layer counter lay (clog2 LAYERS, min 1 bit), FSM state.
- Reset (async): state=IDLE, all vectors 0, idx=0, lay=0, in_ready=1, out_valid=0, busy=0, out_vec=0.
- IDLE: in_ready=1. When in_valid&in_ready: cur_vec<=in_vec, idx<=0, lay<=0, go to EVAL.
- EVAL: busy=1, in_ready=0. Each cycle nxt_vec[idx]<=eval(cur_vec,idx).
  - If idx==NEURONS-1: cur_vec<=nxt_vec with bit idx replaced by the new value, idx<=0.
  - Then, if lay==LAYERS-1, go to DONE; otherwise lay<=lay+1 and stay in EVAL.
  - Otherwise idx<=idx+1.
- Layers never read partially updated vectors; cur_vec changes only at layer end.
- DONE: out_valid=1 and out_vec=cur_vec, both held stable until out_ready. On out_valid&out_ready go to IDLE; out_valid drops next cycle.
- No new input is accepted in DONE (in_ready=0). A back-to-back accept is possible on the cycle after the return to IDLE.
- Latency: accept edge to first out_valid cycle = NEURONS*LAYERS+1 cycles (9 with defaults).
- in_valid during EVAL/DONE is ignored; in_vec is sampled only on accept.
- Reset mid-operation aborts immediately; no partial output is emitted.
- idx and lay wrap only as described above; they never exceed NEURONS-1 or LAYERS-1.

Optional Feature:
- Macro NEURON_SEQ_MASK_EN.
- Defined: adds input port neuron_mask (NEURONS bits), sampled with in_vec on accept into a mask register. Neuron k with mask bit 0 evaluates as disabled (output 0) in every layer.
- Undefined: no port, no register; all neurons always enabled.

Decomposition:
- Shared package neuron_pkg holds:
  - state typedef: IDLE, EVAL, DONE, 2-bit encoding.
  - clog2-derived width localparams for idx, lay and popcount.
  - default constants: NEURONS, CONNECTIONS, THRESHOLD.
- Sub-module neuron_eval (combinational): ports enable, in[CONNECTIONS], out. Implements the popcount-vs-THRESHOLD rule above for any CONNECTIONS. The sequencer instantiates it once, feeding the ring-selected bits.

Test Plan:
- Defaults, in_vec=4'b0000 → layer 1 = 4'b1111, out_vec=4'b0000; out_valid first asserted 9 cycles after accept.
- Defaults, in_vec=4'b0001 → layer 1 = 4'b0110, out_vec=4'b1000; busy high exactly 8 cycles.
- out_ready held low 5 cycles in DONE → out_vec and out_valid stable; in_valid asserted meanwhile is ignored (in_ready=0). Release → IDLE next cycle, then a new vector is accepted.
- rst_n pulsed low during layer 2 → immediately state=IDLE, out_valid=0, in_ready=1. Next in_vec=4'b0001 gives 4'b1000 with no stale data.
- NEURON_SEQ_MASK_EN, neuron_mask=4'b0111, in_vec=4'b0000 → layer 1 = 4'b0111, out_vec=4'b0000. With mask=4'b1111, out_vec=4'b0000.
- LAYERS=1, in_vec=4'b0101 → out_vec=4'b0000 after 5 cycles. Back-to-back vectors with out_ready tied high are each processed with no lost or duplicated outputs.
